// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - state/mode encodings and width helpers for the conv2d MAC engine
package conv2d_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_IMG = 3'd1,
      ST_LOAD_KER = 3'd2,
      ST_MAC      = 3'd3,
      ST_OUT      = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   typedef enum logic {
      MODE_CONV = 1'b0,
      MODE_CORR = 1'b1
   } mode_e;

   // Sum of KER*KER full-width products never overflows this width.
   function automatic int acc_width(input int dw, input int ker);
      return 2 * dw + $clog2(ker * ker);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv2d_mac_engine_if.sv
// rtl/conv2d_mac_engine_if.sv - operand load stream and result stream of the conv2d engine
interface conv2d_mac_engine_if #(
   parameter int DW = 8
);
   logic          ld_valid;
   logic          ld_ready;
   logic [DW-1:0] ld_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output ld_valid, ld_data, out_ready,
      input  ld_ready, out_valid, out_data
   );

   modport slave (
      input  ld_valid, ld_data, out_ready,
      output ld_ready, out_valid, out_data
   );
endinterface

// File: rtl/conv2d_mac.sv
// rtl/conv2d_mac.sv - unsigned DW x DW multiply-accumulate with clear and enable
module conv2d_mac
   import conv2d_pkg::*;
#(
   parameter int DW  = 8,
   parameter int KER = 3,
   localparam int ACC_W = acc_width(DW, KER)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [ACC_W-1:0] acc_next
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(a) * ACC_W'(b);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Exposing the next value lets the engine register the finished pixel on the last product edge.
   assign acc_next = acc_d;

endmodule

// File: rtl/conv2d_mac_engine.sv
// rtl/conv2d_mac_engine.sv - time-multiplexed IMGxIMG by KERxKER convolution engine; CONV_SAT_EN selects saturating output
module conv2d_mac_engine
   import conv2d_pkg::*;
#(
   parameter int IMG = 4,
   parameter int KER = 3,
   parameter int DW  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                mode,
   conv2d_mac_engine_if.slave  bus,
   output logic                busy,
   output logic [2:0]          cur_state
);

   localparam int IMG_N = IMG * IMG;
   localparam int KER_N = KER * KER;
   localparam int OUT_N = IMG - KER + 1;
   localparam int ACC_W = acc_width(DW, KER);
   localparam int IAW   = idx_width(IMG_N);
   localparam int KAW   = idx_width(KER_N);
   localparam int CW    = $clog2(IMG_N + 1);
   localparam int RW    = $clog2(IMG + 1);

   state_e          state_q, state_d;
   mode_e           mode_q, mode_d;
   logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
   logic [KAW-1:0]  k_cnt_q, k_cnt_d;
   logic [RW-1:0]   k_r_q, k_r_d;
   logic [RW-1:0]   k_c_q, k_c_d;
   logic [RW-1:0]   px_r_q, px_r_d;
   logic [RW-1:0]   px_c_q, px_c_d;
   logic            ld_ready_q, ld_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            busy_q, busy_d;

   logic            img_we, ker_we;
   logic            mac_clr, mac_en;
   logic [IAW-1:0]  img_addr;
   logic [KAW-1:0]  ker_addr;
   logic [ACC_W-1:0] acc_next;
   logic [DW-1:0]   result;
   logic            ld_fire;
   logic            last_pixel;

   logic [DW-1:0]   img_mem [IMG_N];
   logic [DW-1:0]   ker_mem [KER_N];

   always_ff @(posedge clk) begin
      if (img_we) begin
         img_mem[ld_cnt_q[IAW-1:0]] <= bus.ld_data;
      end
      if (ker_we) begin
         ker_mem[ld_cnt_q[KAW-1:0]] <= bus.ld_data;
      end
   end

   // Convolution walks the kernel backwards, which is the 180-degree rotation.
   always_comb begin
      img_addr = IAW'((int'(px_r_q) + int'(k_r_q)) * IMG + int'(px_c_q) + int'(k_c_q));
      if (mode_q == MODE_CONV) begin
         ker_addr = KAW'(KER_N - 1 - int'(k_cnt_q));
      end else begin
         ker_addr = k_cnt_q;
      end
   end

   conv2d_mac #(
      .DW  (DW),
      .KER (KER)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clr      (mac_clr),
      .en       (mac_en),
      .a        (img_mem[img_addr]),
      .b        (ker_mem[ker_addr]),
      .acc_next (acc_next)
   );

`ifdef CONV_SAT_EN
   assign result = (|acc_next[ACC_W-1:DW]) ? {DW{1'b1}} : acc_next[DW-1:0];
`else
   assign result = DW'(acc_next);
`endif

   assign ld_fire    = bus.ld_valid && ld_ready_q;
   assign last_pixel = (px_r_q == RW'(OUT_N - 1)) && (px_c_q == RW'(OUT_N - 1));

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      ld_cnt_d    = ld_cnt_q;
      k_cnt_d     = k_cnt_q;
      k_r_d       = k_r_q;
      k_c_d       = k_c_q;
      px_r_d      = px_r_q;
      px_c_d      = px_c_q;
      ld_ready_d  = ld_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      img_we      = 1'b0;
      ker_we      = 1'b0;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d    = ST_LOAD_IMG;
               mode_d     = mode_e'(mode);
               ld_cnt_d   = '0;
               k_cnt_d    = '0;
               k_r_d      = '0;
               k_c_d      = '0;
               px_r_d     = '0;
               px_c_d     = '0;
               ld_ready_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         ST_LOAD_IMG: begin
            if (ld_fire) begin
               img_we = 1'b1;
               if (ld_cnt_q == CW'(IMG_N - 1)) begin
                  ld_cnt_d = '0;
                  state_d  = ST_LOAD_KER;
               end else begin
                  ld_cnt_d = ld_cnt_q + 1'b1;
               end
            end
         end
         ST_LOAD_KER: begin
            if (ld_fire) begin
               ker_we = 1'b1;
               if (ld_cnt_q == CW'(KER_N - 1)) begin
                  ld_cnt_d   = '0;
                  ld_ready_d = 1'b0;
                  mac_clr    = 1'b1;
                  state_d    = ST_MAC;
               end else begin
                  ld_cnt_d = ld_cnt_q + 1'b1;
               end
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (k_cnt_q == KAW'(KER_N - 1)) begin
               k_cnt_d     = '0;
               k_r_d       = '0;
               k_c_d       = '0;
               out_valid_d = 1'b1;
               out_data_d  = result;
               state_d     = ST_OUT;
            end else begin
               k_cnt_d = k_cnt_q + 1'b1;
               if (k_c_q == RW'(KER - 1)) begin
                  k_c_d = '0;
                  k_r_d = k_r_q + 1'b1;
               end else begin
                  k_c_d = k_c_q + 1'b1;
               end
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               mac_clr     = 1'b1;
               if (last_pixel) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_MAC;
                  if (px_c_q == RW'(OUT_N - 1)) begin
                     px_c_d = '0;
                     px_r_d = px_r_q + 1'b1;
                  end else begin
                     px_c_d = px_c_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_CONV;
         ld_cnt_q    <= '0;
         k_cnt_q     <= '0;
         k_r_q       <= '0;
         k_c_q       <= '0;
         px_r_q      <= '0;
         px_c_q      <= '0;
         ld_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         ld_cnt_q    <= ld_cnt_d;
         k_cnt_q     <= k_cnt_d;
         k_r_q       <= k_r_d;
         k_c_q       <= k_c_d;
         px_r_q      <= px_r_d;
         px_c_q      <= px_c_d;
         ld_ready_q  <= ld_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ld_ready  = ld_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
   assign cur_state     = state_q;

endmodule

// File: doc/conv2d_mac_engine.md
# conv2d_mac_engine

Parametrised 2D convolution engine that convolves an IMG×IMG image with a KER×KER kernel using one time-multiplexed multiply-accumulate unit. It generalises the fixed 4×4/3×3 convolution datapath: size and data width are parameters, operands load through a handshaked stream instead of flat ports, a per-run mode selects convolution or correlation, and results leave through a valid/ready output stream. It sits under the design top, fed by the operand loader and drained by the display/result logic.

## Interface
- IMG, 4, image side length (≥ KER)
- KER, 3, kernel side length (≥ 1)
- DW, 8, operand and result width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- run  in  1  start pulse; sampled only in IDLE
- mode  in  1  sampled with run: 0 = convolution (kernel rotated 180°), 1 = correlation
- ld_valid  in  1  load beat valid
- ld_ready  out  1  engine accepts load beat
- ld_data  in  DW  image then kernel words, raster order (row 1 col 1 first)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DW  result pixel, raster order
- busy  out  1  high in any state except IDLE
- cur_state  out  3  FSM state code

## Operation
- States: IDLE=0, LOAD_IMG=1, LOAD_KER=2, MAC=3, OUT=4, DONE=5.
- IDLE: run=1 → latch mode, clear counters → LOAD_IMG.
- LOAD_IMG: ld_ready=1; each ld_valid&&ld_ready stores one word; after IMG² beats → LOAD_KER.
- LOAD_KER: same, KER² beats → MAC with pixel index (0,0), accumulator cleared.
- MAC: one product per cycle, kernel index k=0..KER²−1. Convolution uses kernel[KER−1−r][KER−1−c]; correlation uses kernel[r][c]. After KER² products → OUT.
- OUT: out_valid=1, out_data held stable until out_ready. On handshake: next pixel → MAC with accumulator cleared, or after the (IMG−KER+1)²-th pixel → DONE.
- DONE: one cycle, → IDLE.
- Arithmetic: unsigned; accumulator width 2·DW+clog2(KER²), no internal overflow. out_data = acc[DW−1:0] (mod 2^DW) unless saturation is compiled in.
- run outside IDLE ignored. ld_valid outside load states ignored (ld_ready=0).
- Load stalls (ld_valid=0) and output back-pressure (out_ready=0) hold state indefinitely.

## Timing
- Reset values: ld_ready=0, out_valid=0, out_data=0, busy=0, cur_state=0; counters and accumulator 0; image/kernel storage unspecified.
- reset low mid-operation: next edge returns to IDLE, any pending result discarded.
- run at edge n → cur_state=1, ld_ready=1 after edge n.
- Pixel latency: KER² cycles in MAC, out_valid asserted the cycle after the last product.
- With out_ready tied high and no load stalls: total run = 1 + IMG² + KER² + (IMG−KER+1)²·(KER²+1) + 1 cycles (IMG=4, KER=3: 67).
- out_valid drops the cycle after handshake; no back-to-back outputs (MAC between).

## Configuration
- CONV_SAT_EN defined: out_data = min(acc, 2^DW−1) (unsigned saturation).
- Undefined: out_data = acc mod 2^DW (wrap). Default build leaves it undefined.

## Structure
- Package conv2d_pkg: state encoding constants, accumulator-width function, mode encoding.
- One sub-module: conv2d_mac (DW×DW multiply, accumulate, clear, enable; accumulator width from package).
- Image and kernel storage as register arrays in the engine; address generation in the engine.

## Test plan
- Image 3 1 6 5/7 5 2 7/7 10 8 9/1 3 2 10, kernel 3 1 4/0 5 1/0 1 5, mode=0 → outputs 110, 101, 110, 121.
- Same operands, mode=1 → first output 111.
- Image 1 2 3 0/0 1 2 3/3 0 1 2/2 3 0 1, kernel 2 0 1/0 1 2/1 0 2, mode=0 → 11, 12, 10, 11; out_ready low 5 cycles on second result → out_data held at 12, then continues.
- Image 72 58 36 24/254 210 159 73/89 72 205 101/220 9 87 172, kernel 201 170 24/59 109 187/80 141 210, mode=0 → wrap build 248, 3, 137, 121; CONV_SAT_EN build 255, 255, 255, 255.
- reset low during MAC of second pixel → next cycle cur_state=0, out_valid=0, busy=0; new run then completes with correct results.
- run pulsed while busy and ld_valid toggled in MAC → ignored; result sequence unchanged.
